weight_writer: RTL and testbench
================================

# weight_writer

Write-back end of the network's weight memory. Snapshots the 17 trained weight/bias words (wa11 … bias22) on a start pulse and streams them, one word per accepted cycle, into a 32-bit write port at the same word addresses the weight ROM reads them from. It sits between the training/update logic and the weight memory, so updated parameters land where the next read-out expects them.

## Interface
- DWIDTH, 32, word width (fixed-point, frac=24 format; treated as raw bits)
- AWIDTH, 8, memory address width (256-word memory)
- BASE, 0, address of the first word (wa11)

- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  one-cycle request to write back a new weight set
- wa11, wa12, wa13, wb11, wb12, wb13, wa21, wa22, wb21, wb22, wc21, wc22, bias11, bias12, bias13, bias21, bias22  in  DWIDTH each  weight set to store
- mem_ready  in  1  memory accepts the current word this cycle
- mem_we  out  1  write valid
- mem_addr  out  AWIDTH  write address
- mem_data  out  DWIDTH  write data
- busy  out  1  high whenever state ≠ IDLE
- done  out  1  one-cycle pulse after the last word is accepted

## Operation
- Word order and address offsets are fixed: wa11=0, wa12=1, wa13=2, wb11=3, wb12=4, wb13=5, wa21=6, wa22=7, wb21=8, wb22=9, wc21=10, wc22=11, bias11=12, bias12=13, bias13=14, bias21=15, bias22=16. mem_addr = BASE + offset, truncated to AWIDTH bits, so addresses wrap past 255.
- FSM states: IDLE, WRITE, DONE.
  - IDLE: if start=1, capture all 17 inputs into shadow registers, set idx=0, go to WRITE. Input changes after the capture cycle have no effect on the transfer in progress.
  - WRITE: present shadow[idx] with mem_we=1. A word is transferred in a cycle where mem_we=1 and mem_ready=1.
    - On a transfer with idx<last: idx+1.
    - On a transfer with idx=last: go to DONE.
    - While mem_ready=0: addr, data and we hold unchanged.
  - DONE: done=1 for exactly this cycle, mem_we=0, then go to IDLE.
- start is ignored in WRITE and DONE; it is not queued.
- All outputs are registered.
- Reset values: mem_we=0, mem_addr=0, mem_data=0, busy=0, done=0, idx=0, state=IDLE.
- Asserting rst_n mid-transfer abandons the transfer immediately. Words already transferred stay written, and no done pulse is issued.

## Timing
- Cycle 0: start sampled in IDLE.
- Cycle 1: first word presented (mem_we=1, addr=BASE, data=wa11), and busy goes high.
- With mem_ready held at 1:
  - words are presented on cycles 1–17;
  - done=1 on cycle 18;
  - busy falls at cycle 19 and the block is back in IDLE;
  - the earliest next start is sampled on cycle 19.
- Each cycle of mem_ready=0 during WRITE adds one cycle to the total latency.
- mem_ready is don't-care when mem_we=0.

## Configuration
- WEIGHT_WRITER_CHECKSUM_EN defined:
  - after bias22, one extra word is written at BASE+17;
  - its value is the sum of the 17 snapshot words modulo 2^DWIDTH, computed while the shadow registers are loaded;
  - last = 17, so with mem_ready=1 done falls on cycle 19.
- WEIGHT_WRITER_CHECKSUM_EN undefined:
  - exactly 17 words are written, last = 16, and no checksum logic is present.

## Test plan
- Nominal transfer: reset, inputs set to value 0x0100_0000 + offset, start pulse, mem_ready=1. Required: writes to addr 0..16 on cycles 1–17 with matching data, done on cycle 18, busy high for cycles 1–18.
- Backpressure: mem_ready toggles 1,0,0,1,… Required: every word written exactly once in order, with addr/data stable while mem_ready=0, and done exactly once after the addr-16 transfer.
- Snapshot and ignored start: change all inputs to 0xDEAD_BEEF on cycle 2, and pulse start on cycles 5 and 18. Required: original values written, no second transfer, and a new start on cycle 19 accepted.
- Address wrap: BASE=250. Required: addresses 250..255, then 0..10.
- Reset mid-operation: drop rst_n after the 8th transfer. Required: all outputs 0 asynchronously, no done pulse, and a following start restarts at BASE with wa11.
- Checksum (WEIGHT_WRITER_CHECKSUM_EN): all inputs 0xFFFF_FFFF. Required: word at BASE+17 = 0xFFFF_FFEF, done on cycle 19.

Source files
------------

// File: rtl/weight_writer.sv
// Weight write-back streamer: snapshots 17 weight/bias words on start and writes them out in ROM order.
// Optional macro WEIGHT_WRITER_CHECKSUM_EN appends a modulo-2^DWIDTH checksum word at BASE+17.
module weight_writer #(
   parameter int DWIDTH = 32,
   parameter int AWIDTH = 8,
   parameter int BASE   = 0
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic [DWIDTH-1:0] wa11,
   input  logic [DWIDTH-1:0] wa12,
   input  logic [DWIDTH-1:0] wa13,
   input  logic [DWIDTH-1:0] wb11,
   input  logic [DWIDTH-1:0] wb12,
   input  logic [DWIDTH-1:0] wb13,
   input  logic [DWIDTH-1:0] wa21,
   input  logic [DWIDTH-1:0] wa22,
   input  logic [DWIDTH-1:0] wb21,
   input  logic [DWIDTH-1:0] wb22,
   input  logic [DWIDTH-1:0] wc21,
   input  logic [DWIDTH-1:0] wc22,
   input  logic [DWIDTH-1:0] bias11,
   input  logic [DWIDTH-1:0] bias12,
   input  logic [DWIDTH-1:0] bias13,
   input  logic [DWIDTH-1:0] bias21,
   input  logic [DWIDTH-1:0] bias22,
   input  logic              mem_ready,
   output logic              mem_we,
   output logic [AWIDTH-1:0] mem_addr,
   output logic [DWIDTH-1:0] mem_data,
   output logic              busy,
   output logic              done
);

`ifdef WEIGHT_WRITER_CHECKSUM_EN
   localparam int NWORDS = 18;
`else
   localparam int NWORDS = 17;
`endif
   localparam logic [4:0] LAST = 5'(NWORDS - 1);

   typedef enum logic [1:0] {IDLE, WRITE, DONE} state_t;

   state_t            state_q, state_d;
   logic [4:0]        idx_q, idx_d;
   logic [4:0]        idx_nxt;
   logic              mem_we_q, mem_we_d;
   logic [AWIDTH-1:0] mem_addr_q, mem_addr_d;
   logic [DWIDTH-1:0] mem_data_q, mem_data_d;
   logic              busy_q, busy_d;
   logic              done_q, done_d;

   logic [DWIDTH-1:0] in_w     [17];
   logic [DWIDTH-1:0] snap_w   [NWORDS];
   logic [DWIDTH-1:0] shadow_q [NWORDS];

   function automatic logic [AWIDTH-1:0] addr_of(input logic [4:0] i);
      return AWIDTH'(BASE + int'(i));
   endfunction

   assign in_w[0]  = wa11;   assign in_w[1]  = wa12;   assign in_w[2]  = wa13;
   assign in_w[3]  = wb11;   assign in_w[4]  = wb12;   assign in_w[5]  = wb13;
   assign in_w[6]  = wa21;   assign in_w[7]  = wa22;   assign in_w[8]  = wb21;
   assign in_w[9]  = wb22;   assign in_w[10] = wc21;   assign in_w[11] = wc22;
   assign in_w[12] = bias11; assign in_w[13] = bias12; assign in_w[14] = bias13;
   assign in_w[15] = bias21; assign in_w[16] = bias22;

   always_comb begin
`ifdef WEIGHT_WRITER_CHECKSUM_EN
      logic [DWIDTH-1:0] acc;
      acc = '0;
      for (int i = 0; i < 17; i++) acc = acc + in_w[i];
      snap_w[17] = acc;
`endif
      for (int i = 0; i < 17; i++) snap_w[i] = in_w[i];
   end

   // Shadow registers are pure data: loaded only on an accepted start, no reset needed.
   always_ff @(posedge clk) begin
      if (state_q == IDLE && start) begin
         for (int i = 0; i < NWORDS; i++) shadow_q[i] <= snap_w[i];
      end
   end

   assign idx_nxt = idx_q + 5'd1;

   always_comb begin
      state_d    = state_q;
      idx_d      = idx_q;
      mem_we_d   = mem_we_q;
      mem_addr_d = mem_addr_q;
      mem_data_d = mem_data_q;
      busy_d     = busy_q;
      done_d     = 1'b0;
      case (state_q)
         IDLE: begin
            // First word comes straight from the inputs since the shadow loads on this same edge.
            if (start) begin
               state_d    = WRITE;
               idx_d      = 5'd0;
               mem_we_d   = 1'b1;
               mem_addr_d = addr_of(5'd0);
               mem_data_d = snap_w[0];
               busy_d     = 1'b1;
            end
         end
         WRITE: begin
            if (mem_ready) begin
               if (idx_q == LAST) begin
                  state_d  = DONE;
                  mem_we_d = 1'b0;
                  done_d   = 1'b1;
               end else begin
                  idx_d      = idx_nxt;
                  mem_addr_d = addr_of(idx_nxt);
                  mem_data_d = shadow_q[idx_nxt];
               end
            end
         end
         DONE: begin
            state_d = IDLE;
            busy_d  = 1'b0;
         end
         default: begin
            state_d  = IDLE;
            mem_we_d = 1'b0;
            busy_d   = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         idx_q      <= 5'd0;
         mem_we_q   <= 1'b0;
         mem_addr_q <= '0;
         mem_data_q <= '0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         idx_q      <= idx_d;
         mem_we_q   <= mem_we_d;
         mem_addr_q <= mem_addr_d;
         mem_data_q <= mem_data_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
      end
   end

   assign mem_we   = mem_we_q;
   assign mem_addr = mem_addr_q;
   assign mem_data = mem_data_q;
   assign busy     = busy_q;
   assign done     = done_q;

endmodule

// File: tb/tb_weight_writer.sv
// Self-checking bench for weight_writer: table-driven nominal/snapshot/wrap run plus backpressure, reset and checksum sequences.
module tb_weight_writer;

`ifdef WEIGHT_WRITER_CHECKSUM_EN
   localparam int NW = 18;
`else
   localparam int NW = 17;
`endif

   logic        clk = 1'b0;
   logic        rst_n, start, mem_ready;
   logic [31:0] w [17];
   logic        we0, we1, busy0, busy1, done0, done1;
   logic [7:0]  addr0, addr1;
   logic [31:0] data0, data1;

   int n_cmp = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   weight_writer #(.DWIDTH(32), .AWIDTH(8), .BASE(0)) dut0 (
      .clk(clk), .rst_n(rst_n), .start(start),
      .wa11(w[0]), .wa12(w[1]), .wa13(w[2]), .wb11(w[3]), .wb12(w[4]), .wb13(w[5]),
      .wa21(w[6]), .wa22(w[7]), .wb21(w[8]), .wb22(w[9]), .wc21(w[10]), .wc22(w[11]),
      .bias11(w[12]), .bias12(w[13]), .bias13(w[14]), .bias21(w[15]), .bias22(w[16]),
      .mem_ready(mem_ready), .mem_we(we0), .mem_addr(addr0), .mem_data(data0),
      .busy(busy0), .done(done0));

   weight_writer #(.DWIDTH(32), .AWIDTH(8), .BASE(250)) dut1 (
      .clk(clk), .rst_n(rst_n), .start(start),
      .wa11(w[0]), .wa12(w[1]), .wa13(w[2]), .wb11(w[3]), .wb12(w[4]), .wb13(w[5]),
      .wa21(w[6]), .wa22(w[7]), .wb21(w[8]), .wb22(w[9]), .wc21(w[10]), .wc22(w[11]),
      .bias11(w[12]), .bias12(w[13]), .bias13(w[14]), .bias21(w[15]), .bias22(w[16]),
      .mem_ready(mem_ready), .mem_we(we1), .mem_addr(addr1), .mem_data(data1),
      .busy(busy1), .done(done1));

   typedef struct {
      logic        start;
      logic        ready;
      logic        poke;
      logic        we;
      logic        busy;
      logic        done;
      logic [7:0]  addr;
      logic [7:0]  addr1;
      logic [31:0] data;
   } vec_t;

   vec_t tv [NW+4];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic set_w(input logic [31:0] base, input logic inc);
      for (int i = 0; i < 17; i++) w[i] = inc ? base + 32'(i) : base;
   endtask

   task automatic do_reset();
      #2 rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
   endtask

   function automatic logic [31:0] sum_of(input logic [31:0] base);
      logic [31:0] s;
      s = 32'h0;
      for (int i = 0; i < 17; i++) s = s + base + 32'(i);
      return s;
   endfunction

   initial begin
      logic [31:0] cks, prev_data, expd;
      logic [7:0]  prev_addr;
      logic        held, finished, seen_done;
      int          idx, done_cnt, ntx;

      rst_n = 1'b0; start = 1'b0; mem_ready = 1'b0;
      set_w(32'h0100_0000, 1'b1);
      repeat (2) @(posedge clk);
      #1;
      chk("reset_we", {31'b0, we0}, 32'd0);
      chk("reset_addr", {24'b0, addr0}, 32'd0);
      chk("reset_data", data0, 32'd0);
      chk("reset_busy", {31'b0, busy0}, 32'd0);
      chk("reset_done", {31'b0, done0}, 32'd0);
      chk("reset_addr_b250", {24'b0, addr1}, 32'd0);
      rst_n = 1'b1;

      // Nominal + snapshot + ignored start + address wrap on the BASE=250 instance
      cks = sum_of(32'h0100_0000);
      for (int c = 0; c < NW + 4; c++) begin
         tv[c] = '{default: '0};
         tv[c].start = (c == 0 || c == 5 || c == NW + 1 || c == NW + 2);
         tv[c].ready = 1'b1;
         tv[c].poke  = (c == 2);
         if (c >= 1 && c <= NW) begin
            tv[c].we    = 1'b1;
            tv[c].busy  = 1'b1;
            tv[c].addr  = 8'(c - 1);
            tv[c].addr1 = 8'(250 + c - 1);
            tv[c].data  = (c - 1 < 17) ? 32'h0100_0000 + 32'(c - 1) : cks;
         end else if (c == NW + 1) begin
            tv[c].busy = 1'b1;
            tv[c].done = 1'b1;
         end else if (c == NW + 3) begin
            tv[c].we    = 1'b1;
            tv[c].busy  = 1'b1;
            tv[c].addr  = 8'd0;
            tv[c].addr1 = 8'd250;
            tv[c].data  = 32'hDEAD_BEEF;
         end
      end
      for (int c = 0; c < NW + 4; c++) begin
         start = tv[c].start;
         mem_ready = tv[c].ready;
         if (tv[c].poke) set_w(32'hDEAD_BEEF, 1'b0);
         chk($sformatf("tv%0d_we", c), {31'b0, we0}, {31'b0, tv[c].we});
         chk($sformatf("tv%0d_busy", c), {31'b0, busy0}, {31'b0, tv[c].busy});
         chk($sformatf("tv%0d_done", c), {31'b0, done0}, {31'b0, tv[c].done});
         chk($sformatf("tv%0d_we_b250", c), {31'b0, we1}, {31'b0, tv[c].we});
         if (tv[c].we) begin
            chk($sformatf("tv%0d_addr", c), {24'b0, addr0}, {24'b0, tv[c].addr});
            chk($sformatf("tv%0d_data", c), data0, tv[c].data);
            chk($sformatf("tv%0d_addr_b250", c), {24'b0, addr1}, {24'b0, tv[c].addr1});
            chk($sformatf("tv%0d_data_b250", c), data1, tv[c].data);
         end
         step();
      end
      start = 1'b0;
      do_reset();

      // Backpressure: mem_ready pattern 1,0,0 repeating
      set_w(32'h0200_0000, 1'b1);
      cks = sum_of(32'h0200_0000);
      start = 1'b1;
      step();
      start = 1'b0;
      idx = 0; done_cnt = 0; held = 1'b0; finished = 1'b0;
      prev_addr = '0; prev_data = '0;
      for (int k = 0; k < 200; k++) begin
         mem_ready = (k % 3 == 0);
         if (held) begin
            chk("bp_hold_we", {31'b0, we0}, 32'd1);
            chk("bp_hold_addr", {24'b0, addr0}, {24'b0, prev_addr});
            chk("bp_hold_data", data0, prev_data);
         end
         if (we0) begin
            expd = (idx < 17) ? 32'h0200_0000 + 32'(idx) : cks;
            chk("bp_idx_range", {31'b0, idx < NW}, 32'd1);
            chk("bp_addr", {24'b0, addr0}, 32'(idx));
            chk("bp_data", data0, expd);
            if (mem_ready) idx++;
         end
         held = we0 && !mem_ready;
         prev_addr = addr0;
         prev_data = data0;
         if (done0) begin
            done_cnt++;
            chk("bp_done_after_last", 32'(idx), 32'(NW));
         end
         if (done_cnt > 0 && !busy0) begin
            finished = 1'b1;
            break;
         end
         step();
      end
      chk("bp_finished", {31'b0, finished}, 32'd1);
      chk("bp_words", 32'(idx), 32'(NW));
      chk("bp_done_count", 32'(done_cnt), 32'd1);

      // Reset after the 8th transfer
      set_w(32'h0300_0000, 1'b1);
      mem_ready = 1'b1;
      start = 1'b1;
      step();
      start = 1'b0;
      ntx = 0;
      for (int k = 0; k < 40; k++) begin
         if (we0 && mem_ready) ntx++;
         step();
         if (ntx == 8) break;
      end
      chk("rst_mid_tx8", 32'(ntx), 32'd8);
      #2 rst_n = 1'b0;
      #1;
      chk("rst_mid_we", {31'b0, we0}, 32'd0);
      chk("rst_mid_addr", {24'b0, addr0}, 32'd0);
      chk("rst_mid_data", data0, 32'd0);
      chk("rst_mid_busy", {31'b0, busy0}, 32'd0);
      chk("rst_mid_done", {31'b0, done0}, 32'd0);
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      seen_done = 1'b0;
      for (int k = 0; k < 25; k++) begin
         if (done0 || busy0) seen_done = 1'b1;
         step();
      end
      chk("rst_mid_no_done", {31'b0, seen_done}, 32'd0);
      start = 1'b1;
      step();
      start = 1'b0;
      chk("restart_we", {31'b0, we0}, 32'd1);
      chk("restart_addr", {24'b0, addr0}, 32'd0);
      chk("restart_data", data0, 32'h0300_0000);
      chk("restart_busy", {31'b0, busy0}, 32'd1);

`ifdef WEIGHT_WRITER_CHECKSUM_EN
      do_reset();
      set_w(32'hFFFF_FFFF, 1'b0);
      mem_ready = 1'b1;
      start = 1'b1;
      step();
      start = 1'b0;
      repeat (NW - 1) step();
      chk("cks_we", {31'b0, we0}, 32'd1);
      chk("cks_addr", {24'b0, addr0}, 32'd17);
      chk("cks_data", data0, 32'hFFFF_FFEF);
      step();
      chk("cks_done_cycle19", {31'b0, done0}, 32'd1);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
